// File: rtl/esfa_pkg.sv
// Shared constants for the ESFA cell controller: bus selector opcodes,
// host request op codes and controller FSM state encoding.
package esfa_pkg;

   localparam logic [7:0] SEL_UPDATE    = 8'd0;
   localparam logic [7:0] SEL_LOOKUP    = 8'd1;
   localparam logic [7:0] SEL_ENCODE    = 8'd2;
   localparam logic [7:0] SEL_CONG_UP   = 8'd3;
   localparam logic [7:0] SEL_CONG_DN   = 8'd4;
   localparam logic [7:0] SEL_MARK_FREE = 8'd5;
   localparam logic [7:0] SEL_ENRANK    = 8'd6;
   localparam logic [7:0] SEL_DEBUG     = 8'd7;
   localparam logic [7:0] SEL_IDLE      = 8'hFF;

   typedef enum logic [1:0] {
      OP_INSERT = 2'd0,
      OP_LOOKUP = 2'd1,
      OP_ENCODE = 2'd2,
      OP_ENRANK = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_SAMPLE  = 3'd2,
      ST_WRITE   = 3'd3,
      ST_WSETTLE = 3'd4,
      ST_RESP    = 3'd5
   } state_t;

   // An insert first asks every cell whether it is free.
   function automatic logic [7:0] op_to_sel(input op_t op);
      case (op)
         OP_INSERT: op_to_sel = SEL_MARK_FREE;
         OP_LOOKUP: op_to_sel = SEL_LOOKUP;
         OP_ENCODE: op_to_sel = SEL_ENCODE;
         default:   op_to_sel = SEL_ENRANK;
      endcase
   endfunction

endpackage

// File: rtl/esfa_hit_resolver.sv
// Combinational priority resolver over the per-cell response vectors.
// Multi-hit detection is only built when ESFA_MULTIHIT_CHK_EN is defined.
module esfa_hit_resolver #(
   parameter int NUM_CELLS = 8,
   parameter int DATA_W    = 8,
   parameter int IDX_W     = 3
) (
   input  logic                        i_mode_max_ctx,
   input  logic [NUM_CELLS-1:0]        i_bool,
   input  logic [DATA_W*NUM_CELLS-1:0] i_result,
   input  logic [DATA_W*NUM_CELLS-1:0] i_context,
   output logic                        o_any_hit,
   output logic [IDX_W-1:0]            o_winner,
   output logic [DATA_W-1:0]           o_value,
   output logic [DATA_W-1:0]           o_context
`ifdef ESFA_MULTIHIT_CHK_EN
   ,
   output logic                        o_multi_hit
`endif
);

   logic w_found;

   assign o_any_hit = |i_bool;

   // Ascending scan with strict compare: ties keep the lowest index.
   always_comb begin
      w_found   = 1'b0;
      o_winner  = '0;
      o_value   = '0;
      o_context = '0;
      for (int k = 0; k < NUM_CELLS; k++) begin
         if (i_bool[k]) begin
            if (!w_found ||
                (i_mode_max_ctx && (i_context[k*DATA_W +: DATA_W] > o_context))) begin
               w_found   = 1'b1;
               o_winner  = IDX_W'(k);
               o_value   = i_result[k*DATA_W +: DATA_W];
               o_context = i_context[k*DATA_W +: DATA_W];
            end
         end
      end
   end

`ifdef ESFA_MULTIHIT_CHK_EN
   assign o_multi_hit = |(i_bool & (i_bool - NUM_CELLS'(1)));
`endif

endmodule

// File: rtl/esfa_cell_controller.sv
// Host-request sequencer for the ESFA cell broadcast bus.
// Optional sticky multi-hit flag enabled by ESFA_MULTIHIT_CHK_EN.
//
// state      | meaning
// ST_IDLE    | ready for a host request, bus idle
// ST_ISSUE   | first command on the bus
// ST_SAMPLE  | cell responses valid, resolve winner
// ST_WRITE   | update command writing allocated handle
// ST_WSETTLE | bus idle while the write lands
// ST_RESP    | response held until resp_ready
module esfa_cell_controller
   import esfa_pkg::*;
#(
   parameter int NUM_CELLS = 8,
   parameter int DATA_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [1:0]                  req_op,
   input  logic [DATA_W-1:0]           req_index,
   input  logic [DATA_W-1:0]           req_value,
   input  logic [DATA_W-1:0]           req_array,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic                        resp_ok,
   output logic [DATA_W-1:0]           resp_value,
   output logic [DATA_W-1:0]           resp_context,
   output logic [7:0]                  cell_selector,
   output logic [DATA_W-1:0]           cell_index,
   output logic [DATA_W-1:0]           cell_value,
   output logic [DATA_W-1:0]           cell_metadata,
   output logic                        cell_is_meta,
   input  logic [NUM_CELLS-1:0]        cell_bool,
   input  logic [DATA_W*NUM_CELLS-1:0] cell_result,
   input  logic [DATA_W*NUM_CELLS-1:0] cell_context,
   output logic                        err_multihit
);

   localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

   state_t             r_state, w_next;
   op_t                r_op;
   logic [DATA_W-1:0]  r_index, r_value;
   logic [IDX_W-1:0]   r_handle;
   logic [7:0]         r_sel;
   logic [DATA_W-1:0]  r_bus_index, r_bus_value, r_bus_meta;
   logic               r_bus_is_meta;
   logic               r_resp_valid, r_resp_ok;
   logic [DATA_W-1:0]  r_resp_value, r_resp_context;

   logic               w_accept, w_any_hit, w_do_write;
   logic [IDX_W-1:0]   w_winner;
   logic [DATA_W-1:0]  w_value, w_context;

   assign req_ready     = (r_state == ST_IDLE);
   assign w_accept      = req_valid && req_ready;
   assign w_do_write    = (r_op == OP_INSERT) && w_any_hit;

   assign resp_valid    = r_resp_valid;
   assign resp_ok       = r_resp_ok;
   assign resp_value    = r_resp_value;
   assign resp_context  = r_resp_context;
   assign cell_selector = r_sel;
   assign cell_index    = r_bus_index;
   assign cell_value    = r_bus_value;
   assign cell_metadata = r_bus_meta;
   assign cell_is_meta  = r_bus_is_meta;

`ifdef ESFA_MULTIHIT_CHK_EN
   logic w_multi_hit;
   logic r_multihit;
`endif

   esfa_hit_resolver #(
      .NUM_CELLS (NUM_CELLS),
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W)
   ) u_resolver (
      .i_mode_max_ctx (r_op == OP_LOOKUP),
      .i_bool         (cell_bool),
      .i_result       (cell_result),
      .i_context      (cell_context),
      .o_any_hit      (w_any_hit),
      .o_winner       (w_winner),
      .o_value        (w_value),
      .o_context      (w_context)
`ifdef ESFA_MULTIHIT_CHK_EN
      ,
      .o_multi_hit    (w_multi_hit)
`endif
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_ISSUE;
         ST_ISSUE:   w_next = ST_SAMPLE;
         ST_SAMPLE:  w_next = w_do_write ? ST_WRITE : ST_RESP;
         ST_WRITE:   w_next = ST_WSETTLE;
         ST_WSETTLE: w_next = ST_RESP;
         ST_RESP:    if (resp_ready) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Bus fields fall back to idle every cycle unless a command is loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op           <= OP_INSERT;
         r_index        <= '0;
         r_value        <= '0;
         r_handle       <= '0;
         r_sel          <= SEL_IDLE;
         r_bus_index    <= '0;
         r_bus_value    <= '0;
         r_bus_meta     <= '0;
         r_bus_is_meta  <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_ok      <= 1'b0;
         r_resp_value   <= '0;
         r_resp_context <= '0;
      end else begin
         r_sel         <= SEL_IDLE;
         r_bus_index   <= '0;
         r_bus_value   <= '0;
         r_bus_meta    <= '0;
         r_bus_is_meta <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op          <= op_t'(req_op);
                  r_index       <= req_index;
                  r_value       <= req_value;
                  r_sel         <= op_to_sel(op_t'(req_op));
                  r_bus_index   <= req_index;
                  r_bus_value   <= req_value;
                  r_bus_meta    <= req_array;
                  r_bus_is_meta <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (w_do_write) begin
                  r_handle      <= w_winner;
                  r_sel         <= SEL_UPDATE;
                  r_bus_index   <= r_index;
                  r_bus_value   <= r_value;
                  r_bus_meta    <= DATA_W'(w_winner);
                  r_bus_is_meta <= 1'b1;
               end else begin
                  r_resp_valid   <= 1'b1;
                  r_resp_ok      <= w_any_hit;
                  r_resp_value   <= w_value;
                  r_resp_context <= w_context;
               end
            end
            ST_WSETTLE: begin
               r_resp_valid   <= 1'b1;
               r_resp_ok      <= 1'b1;
               r_resp_value   <= DATA_W'(r_handle);
               r_resp_context <= DATA_W'(r_handle);
            end
            ST_RESP: begin
               if (resp_ready) r_resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef ESFA_MULTIHIT_CHK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_multihit <= 1'b0;
      else if ((r_state == ST_SAMPLE) && w_multi_hit &&
               ((r_op == OP_ENCODE) || (r_op == OP_ENRANK)))
         r_multihit <= 1'b1;
   end
   assign err_multihit = r_multihit;
`else
   assign err_multihit = 1'b0;
`endif

endmodule

// File: tb/tb_esfa_cell_controller.sv
// Self-checking bench for esfa_cell_controller: directed scenarios plus a
// randomized stream compared against a behavioural reference model.
module tb_esfa_cell_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [7:0]  req_index = '0, req_value = '0, req_array = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_ok;
   logic [7:0]  resp_value, resp_context;
   logic [7:0]  cell_selector, cell_index, cell_value, cell_metadata;
   logic        cell_is_meta;
   logic [7:0]  cell_bool = '0;
   logic [63:0] cell_result = '0, cell_context = '0;
   logic        err_multihit;

   int checks = 0;
   int failures = 0;
   logic exp_mh = 1'b0;

   always #5 clk = ~clk;

   esfa_cell_controller #(.NUM_CELLS(8), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_index(req_index), .req_value(req_value), .req_array(req_array),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok),
      .resp_value(resp_value), .resp_context(resp_context),
      .cell_selector(cell_selector), .cell_index(cell_index), .cell_value(cell_value),
      .cell_metadata(cell_metadata), .cell_is_meta(cell_is_meta),
      .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context),
      .err_multihit(err_multihit)
   );

   // Reference behaviour from the request-level rules.
   task automatic ref_model(input logic [1:0] op, input logic [7:0] b,
                            input logic [63:0] res, input logic [63:0] ctx,
                            output logic ok, output logic [7:0] v, output logic [7:0] c,
                            output int lat, output bit wr, output logic [7:0] h);
      int best;
      best = -1;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) begin
            if (best < 0) best = k;
            else if (op == 2'd1 && ctx[k*8 +: 8] > ctx[best*8 +: 8]) best = k;
         end
      end
      wr = 0; h = 8'd0; lat = 3;
      if (best < 0) begin
         ok = 0; v = 8'd0; c = 8'd0;
      end else if (op == 2'd0) begin
         ok = 1; v = 8'(best); c = 8'(best); wr = 1; h = 8'(best); lat = 5;
      end else begin
         ok = 1; v = res[best*8 +: 8]; c = ctx[best*8 +: 8];
      end
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val,
                          input logic [7:0] arr, input logic [7:0] b, input logic [63:0] res,
                          input logic [63:0] ctx, input int hold, input bit b2b);
      logic e_ok, s_ok;
      logic [7:0] e_v, e_c, e_h, e_sel, s_v, s_c, nb;
      logic [63:0] nr, nc;
      int e_lat, cyc, held;
      bit e_wr, seen_wr, seen_resp, handshake, done;
      ref_model(op, b, res, ctx, e_ok, e_v, e_c, e_lat, e_wr, e_h);
      e_sel = (op == 2'd0) ? 8'd5 : (op == 2'd1) ? 8'd1 : (op == 2'd2) ? 8'd2 : 8'd6;
      seen_wr = 0; seen_resp = 0; handshake = 0; done = 0; held = 0;
      s_ok = 0; s_v = 0; s_c = 0;
      req_op = op; req_index = idx; req_value = val; req_array = arr; req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%b want=1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         nb = 8'($urandom); nr = {$urandom, $urandom}; nc = {$urandom, $urandom};
         if (cell_selector === 8'd0) begin
            seen_wr = 1;
            checks++;
            if (cyc != 3 || cell_metadata !== e_h || cell_index !== idx || cell_value !== val || cell_is_meta !== 1'b1) begin
               failures++;
               $display("FAIL write_cmd cyc=%0d meta=%h idx=%h val=%h ism=%b want cyc=3 meta=%h idx=%h val=%h ism=1",
                        cyc, cell_metadata, cell_index, cell_value, cell_is_meta, e_h, idx, val);
            end
         end else if (cell_selector !== 8'hFF) begin
            checks++;
            if (cyc != 1 || cell_selector !== e_sel || cell_metadata !== arr || cell_index !== idx || cell_value !== val || cell_is_meta !== 1'b1) begin
               failures++;
               $display("FAIL issue_cmd cyc=%0d sel=%h meta=%h idx=%h val=%h ism=%b want cyc=1 sel=%h meta=%h idx=%h val=%h ism=1",
                        cyc, cell_selector, cell_metadata, cell_index, cell_value, cell_is_meta, e_sel, arr, idx, val);
            end
            nb = b; nr = res; nc = ctx;
         end
         if (resp_valid === 1'b1) begin
            checks++;
            if (!seen_resp) begin
               seen_resp = 1; s_ok = resp_ok; s_v = resp_value; s_c = resp_context;
               if (cyc != e_lat || resp_ok !== e_ok || resp_value !== e_v || resp_context !== e_c) begin
                  failures++;
                  $display("FAIL resp op=%0d lat=%0d ok=%b val=%h ctx=%h want lat=%0d ok=%b val=%h ctx=%h",
                           op, cyc, resp_ok, resp_value, resp_context, e_lat, e_ok, e_v, e_c);
               end
            end else if (resp_ok !== s_ok || resp_value !== s_v || resp_context !== s_c || req_ready !== 1'b0) begin
               failures++;
               $display("FAIL resp_hold ok=%b val=%h ctx=%h rdy=%b want ok=%b val=%h ctx=%h rdy=0",
                        resp_ok, resp_value, resp_context, req_ready, s_ok, s_v, s_c);
            end
            if (held < hold) begin
               resp_ready = 1'b0; held++;
            end else begin
               resp_ready = 1'b1; handshake = 1;
               if (b2b) req_valid = 1'b1;
               checks++;
               if (req_ready !== 1'b0) begin failures++; $display("FAIL handshake_ready got=%b want=0", req_ready); end
            end
         end
         @(posedge clk); #1;
         cell_bool = nb; cell_result = nr; cell_context = nc;
         if (handshake) begin
            resp_ready = 1'b0; done = 1;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || cell_selector !== 8'hFF) begin
               failures++;
               $display("FAIL post_handshake valid=%b rdy=%b sel=%h want valid=0 rdy=1 sel=ff",
                        resp_valid, req_ready, cell_selector);
            end
         end
         cyc++;
      end
      checks++;
      if (!done) begin failures++; $display("FAIL txn_timeout op=%0d cycles=%0d", op, cyc); end
      checks++;
      if (seen_wr != e_wr) begin failures++; $display("FAIL write_seen got=%0d want=%0d", seen_wr, e_wr); end
`ifdef ESFA_MULTIHIT_CHK_EN
      if ((op == 2'd2 || op == 2'd3) && $countones(b) > 1) exp_mh = 1'b1;
`endif
      checks++;
      if (err_multihit !== exp_mh) begin failures++; $display("FAIL multihit got=%b want=%b", err_multihit, exp_mh); end
   endtask

   task automatic test_reset();
      reset = 1'b0; exp_mh = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cell_selector !== 8'hFF || resp_valid !== 1'b0 || resp_ok !== 1'b0 || resp_value !== 8'd0 ||
          resp_context !== 8'd0 || err_multihit !== 1'b0 || cell_is_meta !== 1'b0 || cell_metadata !== 8'd0) begin
         failures++;
         $display("FAIL reset_state sel=%h valid=%b ok=%b val=%h ctx=%h mh=%b ism=%b meta=%h",
                  cell_selector, resp_valid, resp_ok, resp_value, resp_context, err_multihit, cell_is_meta, cell_metadata);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || cell_selector !== 8'hFF) begin
         failures++; $display("FAIL reset_release rdy=%b sel=%h want rdy=1 sel=ff", req_ready, cell_selector);
      end
   endtask

   task automatic test_reset_mid_write();
      bit bad;
      int n;
      cell_bool = 8'hF0;
      req_op = 2'd0; req_index = 8'h07; req_value = 8'h70; req_array = 8'h01; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (cell_selector !== 8'd0 && n < 10) begin @(posedge clk); #1; n++; end
      checks++;
      if (cell_selector !== 8'd0) begin failures++; $display("FAIL rst_write_reach sel=%h want=00", cell_selector); end
      reset = 1'b0; exp_mh = 1'b0;
      #1;
      checks++;
      if (cell_selector !== 8'hFF || resp_valid !== 1'b0) begin
         failures++; $display("FAIL rst_write_abort sel=%h valid=%b want sel=ff valid=0", cell_selector, resp_valid);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      bad = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || cell_selector !== 8'hFF || req_ready !== 1'b1) bad = 1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL rst_write_quiet bad=%0d want=0", bad); end
   endtask

   task automatic test_insert();
      run_txn(2'd0, 8'd3, 8'h2A, 8'h00, 8'hFF, 64'd0, 64'd0, 0, 0);
      run_txn(2'd0, 8'd9, 8'h33, 8'h04, 8'hA0, 64'd0, 64'd0, 0, 0);
      run_txn(2'd0, 8'd3, 8'h2A, 8'h00, 8'h00, 64'd0, 64'd0, 0, 0);
   endtask

   task automatic test_lookup();
      logic [63:0] r, c;
      r = 64'd0; c = 64'd0;
      r[2*8 +: 8] = 8'h11; r[5*8 +: 8] = 8'h55;
      c[2*8 +: 8] = 8'd1;  c[5*8 +: 8] = 8'd4;
      run_txn(2'd1, 8'd2, 8'h00, 8'h01, 8'b0010_0100, r, c, 0, 0);
      c[5*8 +: 8] = 8'd1;
      run_txn(2'd1, 8'd2, 8'h00, 8'h01, 8'b0010_0100, r, c, 0, 0);
      run_txn(2'd1, 8'd2, 8'h00, 8'h01, 8'h00, r, c, 0, 0);
   endtask

   task automatic test_encode_multihit();
      logic [63:0] r, c;
      r = 64'd0; c = 64'd0;
      r[1*8 +: 8] = 8'hA1; r[6*8 +: 8] = 8'hA6;
      c[1*8 +: 8] = 8'd2;  c[6*8 +: 8] = 8'd9;
      run_txn(2'd2, 8'd1, 8'h00, 8'h02, 8'b0100_0010, r, c, 0, 0);
      run_txn(2'd3, 8'd0, 8'h00, 8'h02, 8'b0100_0000, r, c, 0, 0);
   endtask

   task automatic test_hold();
      run_txn(2'd1, 8'd5, 8'h00, 8'h03, 8'h18, {$urandom, $urandom}, {$urandom, $urandom}, 10, 0);
      run_txn(2'd0, 8'd1, 8'h44, 8'h03, 8'h40, 64'd0, 64'd0, 10, 0);
   endtask

   task automatic test_back_to_back();
      run_txn(2'd2, 8'd4, 8'h00, 8'h05, 8'h0C, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1);
      run_txn(2'd3, 8'd6, 8'h00, 8'h05, 8'h81, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1);
      run_txn(2'd0, 8'd8, 8'h88, 8'h05, 8'h02, 64'd0, 64'd0, 0, 0);
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic [63:0] c;
      for (int i = 0; i < 40; i++) begin
         b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         for (int k = 0; k < 8; k++) c[k*8 +: 8] = 8'($urandom_range(0, 3));
         run_txn(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), b,
                 {$urandom, $urandom}, c, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      test_reset();
      test_insert();
      test_lookup();
      test_encode_multihit();
      test_hold();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      test_reset();
      req_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
